// File: rtl/bch_t2_seq_decoder.sv
// Sequential double-error-correcting binary BCH decoder over GF(2^M).
// Each received word goes through four steps, one after another:
//   1. serial Horner syndromes S1 and S3,
//   2. a one-cycle division-free locator set-up,
//   3. a serial Chien search over every bit position,
//   4. a held result that waits for the consumer.
// The default parameters give the (15,7,2) code.
module bch_t2_seq_decoder #(
   parameter int                     M         = 4,
   parameter int                     K         = 7,
   parameter logic [M:0]             PRIM_POLY = 5'b10011,
   parameter logic [(2**M)-1-K:0]    GEN_POLY  = 9'b111010001
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [(2**M)-2:0]     in_data,
   input  logic                  in_correct_en,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [K-1:0]          out_data,
   output logic [(2**M)-2:0]     out_codeword,
   output logic [1:0]            out_err_cnt,
   output logic                  out_fail
);

   localparam int N  = (2**M) - 1;
   localparam int IW = $clog2(N);

   // GEN_POLY only documents the code; it must still be monic of degree N-K
   if (GEN_POLY[0] != 1'b1 || GEN_POLY[N-K] != 1'b1) begin : g_gen_poly_check
      $error("GEN_POLY must be a degree N-K polynomial with nonzero constant term");
   end

   typedef enum logic [2:0] {IDLE, SYND, LOCATE, CHIEN, DONE} state_t;

   state_t          state;
   logic [N-1:0]    cw;
   logic [N-1:0]    rcv;
   logic            corr;
   logic [M-1:0]    s1;
   logic [M-1:0]    s3;
   logic [M-1:0]    t1;
   logic [M-1:0]    t2;
   logic [IW-1:0]   idx;
   logic [1:0]      roots;
   logic [1:0]      deg;

   logic [M-1:0]    s1_sq;
   logic [M-1:0]    d;
   logic            is_root;
   logic [1:0]      roots_nxt;
   logic [N-1:0]    flip;
   logic [N-1:0]    cw_nxt;

   // Multiply by alpha: shift up and reduce by the primitive polynomial
   function automatic logic [M-1:0] gf_mul_a(input logic [M-1:0] x);
      return {x[M-2:0], 1'b0} ^ (x[M-1] ? PRIM_POLY[M-1:0] : '0);
   endfunction

   // Multiply by alpha^-1: add the polynomial when the constant term is set, then shift down
   function automatic logic [M-1:0] gf_div_a(input logic [M-1:0] x);
      logic [M:0] t;
      t = {1'b0, x} ^ (x[0] ? PRIM_POLY : '0);
      return t[M:1];
   endfunction

   // General field multiply, Horner over the bits of b
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M-1:0] acc;
      acc = '0;
      for (int i = M - 1; i >= 0; i--) begin
         acc = gf_mul_a(acc) ^ (b[i] ? a : '0);
      end
      return acc;
   endfunction

   // Locator terms and the Chien root test / bit flip for the current position
   always_comb begin
      s1_sq     = gf_mul(s1, s1);
      d         = s3 ^ gf_mul(s1_sq, s1);
      is_root   = ((s1 ^ t1 ^ t2) == '0);
      roots_nxt = roots + {1'b0, is_root};
      flip      = {{(N-1){1'b0}}, corr & is_root} << idx;
      cw_nxt    = cw ^ flip;
   end

   // Decoder control FSM with registered handshake and result outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_codeword <= '0;
         out_err_cnt  <= '0;
         out_fail     <= 1'b0;
         s1           <= '0;
         s3           <= '0;
         t1           <= '0;
         t2           <= '0;
         idx          <= '0;
         roots        <= '0;
         deg          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  cw       <= in_data;
                  rcv      <= in_data;
                  corr     <= in_correct_en;
                  s1       <= '0;
                  s3       <= '0;
                  idx      <= IW'(N - 1);
                  in_ready <= 1'b0;
                  state    <= SYND;
               end
            end
            SYND: begin
               s1 <= gf_mul_a(s1) ^ {{(M-1){1'b0}}, cw[idx]};
               s3 <= gf_mul_a(gf_mul_a(gf_mul_a(s3))) ^ {{(M-1){1'b0}}, cw[idx]};
               if (idx == '0) begin
                  state <= LOCATE;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            LOCATE: begin
               if (s1 == '0) begin
                  // S1 = 0: either no error, or a pattern no double error can produce
                  out_fail     <= (s3 != '0);
                  out_err_cnt  <= '0;
                  out_codeword <= cw;
                  out_data     <= cw[N-1:N-K];
                  out_valid    <= 1'b1;
                  state        <= DONE;
               end else begin
                  t1    <= s1_sq;
                  t2    <= d;
                  deg   <= (d == '0) ? 2'd1 : 2'd2;
                  roots <= '0;
                  idx   <= '0;
                  state <= CHIEN;
               end
            end
            CHIEN: begin
               t1    <= gf_div_a(t1);
               t2    <= gf_div_a(gf_div_a(t2));
               cw    <= cw_nxt;
               roots <= roots_nxt;
               if (idx == IW'(N - 1)) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
                  if (roots_nxt != deg) begin
                     // Root count disagrees with locator degree: undo any flips
                     out_fail     <= 1'b1;
                     out_err_cnt  <= '0;
                     out_codeword <= rcv;
                     out_data     <= rcv[N-1:N-K];
                     cw           <= rcv;
                  end else begin
                     out_fail     <= 1'b0;
                     out_err_cnt  <= roots_nxt;
                     out_codeword <= cw_nxt;
                     out_data     <= cw_nxt[N-1:N-K];
                  end
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
